// File: rtl/superh16_int_div.sv
// SuperH16 iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), one op in flight.
// Define SUPERH16_DIV_EARLY_OUT_EN to skip the dividend's leading-zero iterations.
package superh16_pkg;
   parameter int XLEN          = 64;
   parameter int PHYS_REG_BITS = 7;
   parameter int ROB_IDX_BITS  = 8;

   typedef enum logic [5:0] {
      UOP_NOP  = 6'd0,
      UOP_ADD  = 6'd1,
      UOP_MUL  = 6'd8,
      UOP_MULH = 6'd9,
      UOP_DIV  = 6'd12,
      UOP_DIVU = 6'd13,
      UOP_REM  = 6'd14,
      UOP_REMU = 6'd15
   } uop_opcode_t;
endpackage

module superh16_int_div #(
   parameter int XLEN          = superh16_pkg::XLEN,
   parameter int PHYS_REG_BITS = superh16_pkg::PHYS_REG_BITS,
   parameter int ROB_IDX_BITS  = superh16_pkg::ROB_IDX_BITS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      valid,
   output logic                      ready,
   input  superh16_pkg::uop_opcode_t opcode,
   input  logic [XLEN-1:0]           src1,
   input  logic [XLEN-1:0]           src2,
   input  logic [PHYS_REG_BITS-1:0]  dst_tag,
   input  logic [ROB_IDX_BITS-1:0]   rob_idx,
   output logic                      result_valid,
   output logic [XLEN-1:0]           result,
   output logic [PHYS_REG_BITS-1:0]  result_dst_tag,
   output logic [ROB_IDX_BITS-1:0]   result_rob_idx
);
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [XLEN-1:0]          rem_q, dvd_q, dsr_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     is_rem_q, q_neg_q, r_neg_q;
   logic [PHYS_REG_BITS-1:0] tag_q;
   logic [ROB_IDX_BITS-1:0]  rob_q;

   logic             accept, is_div_op, is_signed, op_rem, s1_neg, s2_neg, special;
   logic [XLEN-1:0]  abs1, abs2, special_res, dvd_init;
   logic [CNT_W-1:0] cnt_init;
   logic [XLEN:0]    partial;
   logic             ge;
   logic [XLEN-1:0]  rem_nxt, dvd_nxt, q_fin, r_fin;

`ifdef SUPERH16_DIV_EARLY_OUT_EN
   logic [CNT_W-1:0] lz;

   function automatic int unsigned clz(input logic [XLEN-1:0] v);
      clz = XLEN;
      for (int unsigned i = 0; i < XLEN; i++)
         if (v[i]) clz = XLEN - 1 - i;
   endfunction
`endif

   assign ready        = (state == IDLE);
   assign accept       = valid && ready && !flush;
   assign result_valid = (state == DONE) && !flush;

   always_comb begin
      is_div_op = 1'b0;
      is_signed = 1'b0;
      op_rem    = 1'b0;
      case (opcode)
         superh16_pkg::UOP_DIV:  begin is_div_op = 1'b1; is_signed = 1'b1; end
         superh16_pkg::UOP_DIVU: begin is_div_op = 1'b1; end
         superh16_pkg::UOP_REM:  begin is_div_op = 1'b1; is_signed = 1'b1; op_rem = 1'b1; end
         superh16_pkg::UOP_REMU: begin is_div_op = 1'b1; op_rem = 1'b1; end
         default: ;
      endcase
      s1_neg = is_signed & src1[XLEN-1];
      s2_neg = is_signed & src2[XLEN-1];
      abs1   = s1_neg ? -src1 : src1;
      abs2   = s2_neg ? -src2 : src2;

      special     = 1'b0;
      special_res = '0;
      if (!is_div_op) begin
         special = 1'b1;
      end else if (src2 == '0) begin
         special     = 1'b1;
         special_res = op_rem ? src1 : '1;
      end else if (is_signed && src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == '1) begin
         special     = 1'b1;
         special_res = op_rem ? '0 : src1;
      end
`ifdef SUPERH16_DIV_EARLY_OUT_EN
      else if (src1 == '0) begin
         special = 1'b1;
      end
`endif

`ifdef SUPERH16_DIV_EARLY_OUT_EN
      lz       = CNT_W'(clz(abs1));
      dvd_init = abs1 << lz;
      cnt_init = CNT_W'(XLEN - 1) - lz;
`else
      dvd_init = abs1;
      cnt_init = CNT_W'(XLEN - 1);
`endif
   end

   // Quotient bits shift into the vacated low end of the dividend register.
   always_comb begin
      partial = {rem_q, dvd_q[XLEN-1]};
      ge      = partial >= {1'b0, dsr_q};
      rem_nxt = ge ? partial[XLEN-1:0] - dsr_q : partial[XLEN-1:0];
      dvd_nxt = {dvd_q[XLEN-2:0], ge};
      q_fin   = q_neg_q ? -dvd_nxt : dvd_nxt;
      r_fin   = r_neg_q ? -rem_nxt : rem_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? DONE : CALC;
         CALC: if (cnt_q == '0) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   // Result registers are written on the edge entering DONE so they line up with result_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q          <= '0;
         dvd_q          <= '0;
         dsr_q          <= '0;
         cnt_q          <= '0;
         is_rem_q       <= 1'b0;
         q_neg_q        <= 1'b0;
         r_neg_q        <= 1'b0;
         tag_q          <= '0;
         rob_q          <= '0;
         result         <= '0;
         result_dst_tag <= '0;
         result_rob_idx <= '0;
      end else if (accept) begin
         rem_q    <= '0;
         dvd_q    <= dvd_init;
         dsr_q    <= abs2;
         cnt_q    <= cnt_init;
         is_rem_q <= op_rem;
         q_neg_q  <= s1_neg ^ s2_neg;
         r_neg_q  <= s1_neg;
         tag_q    <= dst_tag;
         rob_q    <= rob_idx;
         if (special) begin
            result         <= special_res;
            result_dst_tag <= dst_tag;
            result_rob_idx <= rob_idx;
         end
      end else if (state == CALC && !flush) begin
         rem_q <= rem_nxt;
         dvd_q <= dvd_nxt;
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
         end else begin
            result         <= is_rem_q ? r_fin : q_fin;
            result_dst_tag <= tag_q;
            result_rob_idx <= rob_q;
         end
      end
   end
endmodule

// File: tb/tb_superh16_int_div.sv
// Randomized self-checking bench for superh16_int_div against a plain-arithmetic reference model.
module tb_superh16_int_div;
   import superh16_pkg::*;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic                     clk = 1'b0;
   logic                     rst_n, flush, valid, ready, result_valid;
   uop_opcode_t              opcode;
   logic [63:0]              src1, src2, result;
   logic [PHYS_REG_BITS-1:0] dst_tag, result_dst_tag;
   logic [ROB_IDX_BITS-1:0]  rob_idx, result_rob_idx;

   int n_vec = 0;
   int n_err = 0;

   superh16_int_div dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .valid(valid), .ready(ready),
      .opcode(opcode), .src1(src1), .src2(src2), .dst_tag(dst_tag), .rob_idx(rob_idx),
      .result_valid(result_valid), .result(result),
      .result_dst_tag(result_dst_tag), .result_rob_idx(result_rob_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_special(input uop_opcode_t op, input logic [63:0] a, input logic [63:0] b);
      case (op)
         UOP_DIVU, UOP_REMU: return b == 64'd0;
         UOP_DIV, UOP_REM:   return (b == 64'd0) || (a == MIN64 && b == '1);
         default:            return 1'b1;
      endcase
   endfunction

   function automatic logic [63:0] ref_result(input uop_opcode_t op, input logic [63:0] a, input logic [63:0] b);
      longint sa = a;
      longint sb = b;
      case (op)
         UOP_DIVU: return (b == 0) ? '1 : a / b;
         UOP_REMU: return (b == 0) ? a : a % b;
         UOP_DIV: begin
            if (b == 0) return '1;
            if (a == MIN64 && b == '1) return a;
            return sa / sb;
         end
         UOP_REM: begin
            if (b == 0) return a;
            if (a == MIN64 && b == '1) return 64'd0;
            return sa % sb;
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 7))
         0, 1:    return {$urandom, $urandom};
         2:       return 64'($urandom_range(0, 1000));
         3:       return -(64'($urandom_range(1, 1000)));
         4:       return 64'd0;
         5:       return MIN64;
         6:       return '1;
         default: return {32'd0, $urandom};
      endcase
   endfunction

   // Called #1 after the accepting edge; returns at the negedge of the cycle after the result pulse.
   task automatic wait_result(input string tag, input logic [63:0] exp, input int exp_lat,
                              input logic [PHYS_REG_BITS-1:0] exp_tag, input logic [ROB_IDX_BITS-1:0] exp_rob);
      int cyc = 0;
      bit found = 0;
      while (!found && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, "_busy"}, 64'(ready), 64'd0);
         if (result_valid) found = 1;
      end
      check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
      check({tag, "_res"}, result, exp);
      check({tag, "_tag"}, 64'(result_dst_tag), 64'(exp_tag));
      check({tag, "_rob"}, 64'(result_rob_idx), 64'(exp_rob));
      @(negedge clk);
      check({tag, "_rdy"}, 64'(ready), 64'd1);
   endtask

   task automatic issue(input string tag, input uop_opcode_t op, input logic [63:0] a, input logic [63:0] b);
      logic [PHYS_REG_BITS-1:0] dt = PHYS_REG_BITS'($urandom);
      logic [ROB_IDX_BITS-1:0]  ri = ROB_IDX_BITS'($urandom);
      @(negedge clk);
      valid = 1'b1; opcode = op; src1 = a; src2 = b; dst_tag = dt; rob_idx = ri;
      @(posedge clk);
      #1 valid = 1'b0;
      wait_result(tag, ref_result(op, a, b), is_special(op, a, b) ? 1 : 65, dt, ri);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      uop_opcode_t ops[5] = '{UOP_DIV, UOP_DIVU, UOP_REM, UOP_REMU, UOP_MUL};
      int rv_seen;

      rst_n = 1'b0; flush = 1'b0; valid = 1'b0; opcode = UOP_NOP;
      src1 = '0; src2 = '0; dst_tag = '0; rob_idx = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_rv", 64'(result_valid), 64'd0);
      check("rst_res", result, 64'd0);
      check("rst_tag", 64'(result_dst_tag), 64'd0);
      check("rst_rob", 64'(result_rob_idx), 64'd0);
      rst_n = 1'b1;

      issue("divu_100_7", UOP_DIVU, 64'd100, 64'd7);
      issue("rem_m100_7", UOP_REM, -64'd100, 64'd7);
      issue("div_m100_7", UOP_DIV, -64'd100, 64'd7);
      issue("div_7_m2", UOP_DIV, 64'd7, -64'd2);
      issue("div_5_0", UOP_DIV, 64'd5, 64'd0);
      issue("remu_5_0", UOP_REMU, 64'd5, 64'd0);
      issue("rem_m5_0", UOP_REM, -64'd5, 64'd0);
      issue("div_ovf", UOP_DIV, MIN64, '1);
      issue("rem_ovf", UOP_REM, MIN64, '1);
      issue("divu_min_m1", UOP_DIVU, MIN64, '1);
      issue("non_div", UOP_MUL, 64'd12, 64'd3);
      issue("divu_0_9", UOP_DIVU, 64'd0, 64'd9);

      for (int i = 0; i < 40; i++)
         issue("rand", ops[$urandom_range(0, 4)], rnd_operand(), rnd_operand());

      // Flush in the middle of CALC: killed op never reports, next op accepted right away.
      @(negedge clk);
      valid = 1'b1; opcode = UOP_DIVU; src1 = 64'd1000; src2 = 64'd3;
      @(posedge clk);
      #1 valid = 1'b0;
      rv_seen = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (result_valid) rv_seen++;
         if (k == 30) flush = 1'b1;
      end
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_rv", 64'(rv_seen), 64'd0);
      check("flush_ready", 64'(ready), 64'd1);
      issue("post_flush", UOP_DIVU, 64'd100, 64'd7);

      // Flush together with valid must block acceptance.
      @(negedge clk);
      valid = 1'b1; flush = 1'b1; opcode = UOP_DIVU; src1 = 64'd9; src2 = 64'd3;
      @(posedge clk);
      #1 valid = 1'b0; flush = 1'b0;
      rv_seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (result_valid || !ready) rv_seen++;
      end
      check("flush_blk", 64'(rv_seen), 64'd0);

      // valid held through a busy op: the second op waits until ready.
      begin
         logic [63:0] a = {$urandom, $urandom};
         logic [63:0] b = 64'($urandom_range(1, 100000));
         logic [PHYS_REG_BITS-1:0] ta = 7'd11, tb2 = 7'd22;
         logic [ROB_IDX_BITS-1:0]  ra = 8'd33, rb = 8'd44;
         @(negedge clk);
         valid = 1'b1; opcode = UOP_DIVU; src1 = a; src2 = b; dst_tag = ta; rob_idx = ra;
         @(posedge clk);
         #1 opcode = UOP_REM; src1 = -64'd100; src2 = 64'd7; dst_tag = tb2; rob_idx = rb;
         wait_result("held_a", a / b, 65, ta, ra);
         @(posedge clk);
         #1 valid = 1'b0;
         wait_result("held_b", -64'd2, 65, tb2, rb);
      end

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      valid = 1'b1; opcode = UOP_DIVU; src1 = 64'd12345; src2 = 64'd11;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_ready", 64'(ready), 64'd1);
      check("arst_rv", 64'(result_valid), 64'd0);
      check("arst_res", result, 64'd0);
      check("arst_tag", 64'(result_dst_tag), 64'd0);
      check("arst_rob", 64'(result_rob_idx), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rv_seen = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (result_valid) rv_seen++;
      end
      check("arst_no_pulse", 64'(rv_seen), 64'd0);
      issue("post_reset", UOP_REMU, 64'd12345, 64'd11);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
